// File: rtl/spi_flash_rescue_pkg.sv
// Shared types and constants for the N25Q power-loss rescue sequencer:
// FSM state encoding, Flag Status Register opcode and bit positions.
package spi_flash_rescue_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RQ,
    S_G1,
    S_RD,
    S_G2,
    S_RE,
    S_G3,
    S_P2,
    S_WAIT,
    S_CMD,
    S_RDB,
    S_PG,
    S_FIN
  } state_e;

  localparam logic [7:0] FSR_READ_OP = 8'h70;

  localparam int FSR_READY = 7;
  localparam int FSR_ERASE = 5;
  localparam int FSR_PROG  = 4;
  localparam int FSR_VPP   = 3;
  localparam int FSR_PROT  = 1;

  // Opcode (8 pulses) and FSR byte (8 pulses) share one chip-select frame.
  localparam int POLL_FRAME_PULSES = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Any of the error/protection flags FSR[5:1] set.
  function automatic logic fsr_error(input logic [7:0] fsr);
    return fsr[FSR_ERASE] | fsr[FSR_PROG] | fsr[FSR_VPP] | fsr[FSR_VPP-1] | fsr[FSR_PROT];
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: while go_i is high, emits count_i SPI mode-0 pulses of
// CLK_DIV cycles low then CLK_DIV cycles high, followed by one trailing low
// half-period. Strobes mark the clk cycle on which SCK rises or falls, and
// last_o marks the end of the trailing low half-period (frame may close).
module spi_sck_gen #(
  parameter int CLK_DIV = 2,
  parameter int CNT_W   = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             go_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             sck_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             last_o
);

  localparam int DW = $clog2(CLK_DIV + 1);

  logic [DW-1:0]    div_q;
  logic [CNT_W-1:0] pulses_q;
  logic             half_end;

  assign half_end = (div_q == DW'(CLK_DIV - 1));
  assign rise_o   = go_i && !sck_o && half_end && (pulses_q != count_i);
  assign fall_o   = go_i &&  sck_o && half_end;
  assign last_o   = go_i && !sck_o && half_end && (pulses_q == count_i);

  // Half-period divider, SCK toggle and completed-pulse counter.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    if (!rst_ni || !go_i) begin
      div_q    <= '0;
      pulses_q <= '0;
      sck_o    <= 1'b0;
    end else if (half_end) begin
      div_q <= '0;
      if (sck_o) begin
        sck_o    <= 1'b0;
        pulses_q <= pulses_q + 1'b1;
      end else if (pulses_q != count_i) begin
        sck_o <= 1'b1;
      end
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_flash_rescue_seq.sv
// Power-loss rescue sequencer for N25Q-class serial NOR flash. Drives the
// quad/dual/extended part-1 rescue frames and the part-2 frame, waits the
// recovery time, then polls the Flag Status Register until ready or timeout.
// Optional build macro FLASH_RESCUE_ERRCHK_EN adds err_o and stops polling
// early on any of FSR[5:1].
module spi_flash_rescue_seq
  import spi_flash_rescue_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int N_QUAD    = 7,
  parameter int N_DUAL    = 13,
  parameter int N_EXT     = 25,
  parameter int N_P2      = 8,
  parameter int CS_GAP    = 4,
  parameter int RESC_WAIT = 16,
  parameter int POLL_MAX  = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       skip_rescue_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_o,
`ifdef FLASH_RESCUE_ERRCHK_EN
  output logic       err_o,
`endif
  output logic [7:0] fsr_o,
  output logic       sck_o,
  output logic       csn_o,
  output logic [3:0] sd_o,
  output logic [3:0] sd_oe_o,
  input  logic [3:0] sd_i
);

  localparam int MAX_PULSES = max_int(max_int(max_int(N_QUAD, N_DUAL), max_int(N_EXT, N_P2)),
                                      POLL_FRAME_PULSES);
  localparam int PCW = $clog2(MAX_PULSES + 1);
  localparam int GCW = $clog2(max_int(CS_GAP, RESC_WAIT) + 1);
  localparam int QW  = $clog2(POLL_MAX + 1);
  localparam int BW  = $clog2(8);

  state_e         state_q;
  logic           run_q;
  logic [PCW-1:0] frame_len_q;
  logic [GCW-1:0] cnt_q;
  logic [QW-1:0]  poll_q;
  logic [BW-1:0]  bit_cnt_q;
  logic [7:0]     shift_q;
  logic           sck_rise;
  logic           sck_fall;
  logic           sck_last;
  logic           stop_err;
  logic           unused_sd;

  // Only DQ1 carries flash output data.
  assign unused_sd = ^{sd_i[3:2], sd_i[0]};

`ifdef FLASH_RESCUE_ERRCHK_EN
  assign stop_err = fsr_error(fsr_o);
`else
  assign stop_err = 1'b0;
`endif

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (PCW)
  ) u_sck_gen (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .go_i    (run_q),
    .count_i (frame_len_q),
    .sck_o   (sck_o),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall),
    .last_o  (sck_last)
  );

  // Sequencer FSM with registered pin and status outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      frame_len_q <= '0;
      cnt_q       <= '0;
      poll_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
`ifdef FLASH_RESCUE_ERRCHK_EN
      err_o       <= 1'b0;
`endif
      fsr_o       <= 8'h00;
      csn_o       <= 1'b1;
      sd_o        <= 4'b0000;
      sd_oe_o     <= 4'b0000;
    end else begin
      // NOTE: done_o defaults low every cycle; only the FIN entry raises it,
      // which keeps it a single-cycle pulse without a separate clear state.
      done_o <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_o    <= 1'b1;
            fsr_o     <= 8'h00;
            timeout_o <= 1'b0;
`ifdef FLASH_RESCUE_ERRCHK_EN
            err_o     <= 1'b0;
`endif
            poll_q    <= '0;
            csn_o     <= 1'b0;
            run_q     <= 1'b1;
            sd_oe_o   <= 4'b0001;
            if (skip_rescue_i) begin
              state_q     <= S_CMD;
              frame_len_q <= PCW'(POLL_FRAME_PULSES);
              sd_o        <= {3'b000, FSR_READ_OP[7]};
              shift_q     <= {FSR_READ_OP[6:0], 1'b0};
              bit_cnt_q   <= '0;
            end else begin
              state_q     <= S_RQ;
              frame_len_q <= PCW'(N_QUAD);
              sd_o        <= 4'b0001;
            end
          end
        end

        S_RQ, S_RD, S_RE, S_P2: begin
          if (sck_last) begin
            csn_o   <= 1'b1;
            run_q   <= 1'b0;
            sd_o    <= 4'b0000;
            sd_oe_o <= 4'b0000;
            cnt_q   <= '0;
            case (state_q)
              S_RQ:    state_q <= S_G1;
              S_RD:    state_q <= S_G2;
              S_RE:    state_q <= S_G3;
              default: state_q <= S_WAIT;
            endcase
          end
        end

        S_G1, S_G2, S_G3: begin
          if (cnt_q == GCW'(CS_GAP - 1)) begin
            csn_o   <= 1'b0;
            run_q   <= 1'b1;
            sd_o    <= 4'b0001;
            sd_oe_o <= 4'b0001;
            case (state_q)
              S_G1: begin
                state_q     <= S_RD;
                frame_len_q <= PCW'(N_DUAL);
              end
              S_G2: begin
                state_q     <= S_RE;
                frame_len_q <= PCW'(N_EXT);
              end
              default: begin
                state_q     <= S_P2;
                frame_len_q <= PCW'(N_P2);
              end
            endcase
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_WAIT: begin
          if (cnt_q == GCW'(RESC_WAIT - 1)) begin
            state_q     <= S_CMD;
            csn_o       <= 1'b0;
            run_q       <= 1'b1;
            frame_len_q <= PCW'(POLL_FRAME_PULSES);
            sd_oe_o     <= 4'b0001;
            sd_o        <= {3'b000, FSR_READ_OP[7]};
            shift_q     <= {FSR_READ_OP[6:0], 1'b0};
            bit_cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // Opcode goes out MSB first; each new bit is set up on an SCK fall.
        S_CMD: begin
          if (sck_fall) begin
            if (bit_cnt_q == BW'(7)) begin
              state_q   <= S_RDB;
              sd_o      <= 4'b0000;
              sd_oe_o   <= 4'b0000;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              sd_o      <= {3'b000, shift_q[7]};
              shift_q   <= {shift_q[6:0], 1'b0};
            end
          end
        end

        // FSR byte arrives MSB first on DQ1, sampled as SCK rises.
        S_RDB: begin
          if (sck_rise) begin
            shift_q   <= {shift_q[6:0], sd_i[1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == BW'(7)) begin
              fsr_o <= {shift_q[6:0], sd_i[1]};
            end
          end
          if (sck_last) begin
            csn_o   <= 1'b1;
            run_q   <= 1'b0;
            poll_q  <= poll_q + 1'b1;
            cnt_q   <= '0;
            state_q <= S_PG;
          end
        end

        // Ready wins over error, error wins over running out of polls.
        S_PG: begin
          if (cnt_q == GCW'(CS_GAP - 1)) begin
            if (fsr_o[FSR_READY] || stop_err || (poll_q == QW'(POLL_MAX))) begin
              state_q   <= S_FIN;
              done_o    <= 1'b1;
              busy_o    <= 1'b0;
              timeout_o <= !fsr_o[FSR_READY] && !stop_err;
`ifdef FLASH_RESCUE_ERRCHK_EN
              err_o     <= stop_err;
`endif
            end else begin
              state_q     <= S_CMD;
              csn_o       <= 1'b0;
              run_q       <= 1'b1;
              frame_len_q <= PCW'(POLL_FRAME_PULSES);
              sd_oe_o     <= 4'b0001;
              sd_o        <= {3'b000, FSR_READ_OP[7]};
              shift_q     <= {FSR_READ_OP[6:0], 1'b0};
              bit_cnt_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_FIN: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_rescue_seq.sv
// Self-checking bench for spi_flash_rescue_seq. A pin-level monitor records
// every chip-select frame (pulse count, DQ0 bits, enables, SCK timing, gaps)
// and plays a flash that returns a queued list of FSR bytes; each scenario is
// compared against a frame list derived from the sequencing rules.
module tb_spi_flash_rescue_seq;
  import spi_flash_rescue_pkg::*;

  localparam int CLK_DIV   = 2;
  localparam int N_QUAD    = 7;
  localparam int N_DUAL    = 13;
  localparam int N_EXT     = 25;
  localparam int N_P2      = 8;
  localparam int CS_GAP    = 4;
  localparam int RESC_WAIT = 16;
  localparam int POLL_MAX  = 8;
`ifdef FLASH_RESCUE_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic       skip_rescue_i;
  logic       busy_o, done_o, timeout_o;
  logic [7:0] fsr_o;
  logic       sck_o, csn_o;
  logic [3:0] sd_o, sd_oe_o;
  logic [3:0] sd_i = 4'b0000;
`ifdef FLASH_RESCUE_ERRCHK_EN
  logic       err_o;
`endif

  spi_flash_rescue_seq #(
    .CLK_DIV(CLK_DIV), .N_QUAD(N_QUAD), .N_DUAL(N_DUAL), .N_EXT(N_EXT), .N_P2(N_P2),
    .CS_GAP(CS_GAP), .RESC_WAIT(RESC_WAIT), .POLL_MAX(POLL_MAX)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .skip_rescue_i(skip_rescue_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
`ifdef FLASH_RESCUE_ERRCHK_EN
    .err_o(err_o),
`endif
    .fsr_o(fsr_o), .sck_o(sck_o), .csn_o(csn_o), .sd_o(sd_o), .sd_oe_o(sd_oe_o), .sd_i(sd_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor / flash model state
  logic [7:0]  resp[$];
  int          f_len[$];
  int          f_gap[$];
  logic [31:0] f_bits[$];
  logic [31:0] f_oe[$];
  bit          f_terr[$];
  bit          prev_csn = 1'b1;
  bit          prev_sck = 1'b0;
  logic [3:0]  prev_sd = 4'b0000;
  int          lvl_cnt = 0;
  int          gap_cnt = 0;
  int          cur_len = 0;
  int          cur_gap = 0;
  logic [31:0] cur_bits = '0;
  logic [31:0] cur_oe = '0;
  bit          cur_terr = 1'b0;
  logic [7:0]  cur_fsr = 8'h00;
  int          poll_idx = 0;
  int          done_cnt = 0;
  logic [7:0]  done_fsr = 8'h00;
  logic        done_to = 1'b0;
  logic        done_busy = 1'b0;
  logic        done_err = 1'b0;
  bit          idle_err = 1'b0;

  function automatic logic [7:0] resp_at(input int i);
    if (resp.size() == 0) return 8'h00;
    if (i < resp.size()) return resp[i];
    return resp[resp.size()-1];
  endfunction

  // Pin monitor and flash responder, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (done_o) begin
      done_cnt++;
      done_fsr  = fsr_o;
      done_to   = timeout_o;
      done_busy = busy_o;
`ifdef FLASH_RESCUE_ERRCHK_EN
      done_err  = err_o;
`endif
    end
    if (!csn_o) begin
      if (prev_csn) begin
        cur_len  = 0;
        cur_bits = '0;
        cur_oe   = '0;
        cur_terr = 1'b0;
        cur_gap  = gap_cnt;
        lvl_cnt  = 0;
        prev_sck = 1'b0;
        prev_sd  = sd_o;
        cur_fsr  = resp_at(poll_idx);
      end
      if (sck_o != prev_sck) begin
        if (lvl_cnt != CLK_DIV) cur_terr = 1'b1;
        lvl_cnt = 1;
        if (sck_o) begin
          cur_bits = {cur_bits[30:0], sd_o[0]};
          cur_oe   = {cur_oe[30:0], sd_oe_o[0]};
          if (sd_oe_o[3:1] != 3'b000) cur_terr = 1'b1;
          cur_len++;
        end
      end else begin
        lvl_cnt++;
      end
      if (sck_o && (sd_o != prev_sd)) cur_terr = 1'b1;
      if (cur_len >= 8 && cur_len <= 15) sd_i = {2'b00, cur_fsr[15 - cur_len], 1'b0};
      else sd_i = 4'b0000;
    end else begin
      if (!prev_csn) begin
        if (prev_sck || lvl_cnt != CLK_DIV) cur_terr = 1'b1;
        f_len.push_back(cur_len);
        f_gap.push_back(cur_gap);
        f_bits.push_back(cur_bits);
        f_oe.push_back(cur_oe);
        f_terr.push_back(cur_terr);
        if (cur_len == POLL_FRAME_PULSES) poll_idx++;
        gap_cnt = 0;
      end
      if (sck_o) idle_err = 1'b1;
      gap_cnt++;
      sd_i = 4'b0000;
    end
    prev_csn = csn_o;
    prev_sck = sck_o;
    prev_sd  = sd_o;
  end

  task automatic clear_monitor();
    f_len.delete(); f_gap.delete(); f_bits.delete(); f_oe.delete(); f_terr.delete();
    done_cnt = 0;
    poll_idx = 0;
    idle_err = 1'b0;
  endtask

  task automatic do_start(input bit skip);
    @(negedge clk);
    start_i = 1'b1;
    skip_rescue_i = skip;
    @(negedge clk);
    start_i = 1'b0;
    skip_rescue_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (done_cnt == 0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt == 0) begin
      n_errors++;
      $display("FAIL %s: done_o not seen within 5000 cycles", name);
    end
  endtask

  // Expected behaviour from the sequencing rules, compared with the monitor log.
  task automatic compare_with_model(input string name, input bit skip);
    int          n_polls, n_pre, n_exp, exp_len, exp_gap;
    logic [7:0]  exp_fsr;
    bit          exp_to, exp_err;
    logic [31:0] exp_bits, exp_oe;
    n_polls = 0;
    exp_to  = 1'b1;
    exp_fsr = 8'h00;
    for (int i = 0; i < POLL_MAX; i++) begin
      exp_fsr = resp_at(i);
      n_polls = i + 1;
      if (exp_fsr[7] || (ERRCHK && (exp_fsr[5:1] != 5'b0))) begin
        exp_to = 1'b0;
        break;
      end
    end
    exp_err = ERRCHK && (exp_fsr[5:1] != 5'b0);
    n_pre = skip ? 0 : 4;
    n_exp = n_pre + n_polls;

    n_checks++;
    if (f_len.size() !== n_exp) begin
      n_errors++;
      $display("FAIL %s frames: got %0d expected %0d", name, f_len.size(), n_exp);
    end
    for (int k = 0; k < n_exp && k < f_len.size(); k++) begin
      if (k < n_pre) begin
        exp_len  = (k == 0) ? N_QUAD : (k == 1) ? N_DUAL : (k == 2) ? N_EXT : N_P2;
        exp_bits = (32'h1 << exp_len) - 32'h1;
        exp_oe   = exp_bits;
      end else begin
        exp_len  = 16;
        exp_bits = {16'h0, FSR_READ_OP, 8'h00};
        exp_oe   = 32'h0000_FF00;
      end
      exp_gap = (k == 4 && !skip) ? RESC_WAIT : CS_GAP;
      n_checks++;
      if (f_len[k] !== exp_len || f_bits[k] !== exp_bits || f_oe[k] !== exp_oe || f_terr[k]) begin
        n_errors++;
        $display("FAIL %s frame%0d: len %0d bits %h oe %h timing_err %0d, expected len %0d bits %h oe %h",
                 name, k, f_len[k], f_bits[k], f_oe[k], f_terr[k], exp_len, exp_bits, exp_oe);
      end
      if (k > 0) begin
        n_checks++;
        if (f_gap[k] !== exp_gap) begin
          n_errors++;
          $display("FAIL %s gap%0d: got %0d expected %0d", name, k, f_gap[k], exp_gap);
        end
      end
    end
    n_checks++;
    if (done_cnt !== 1 || done_busy !== 1'b0 || idle_err) begin
      n_errors++;
      $display("FAIL %s done: pulses %0d busy_at_done %b idle_sck %0d, expected 1 pulse busy 0",
               name, done_cnt, done_busy, idle_err);
    end
    n_checks++;
    if (done_fsr !== exp_fsr || done_to !== exp_to) begin
      n_errors++;
      $display("FAIL %s status: fsr %h timeout %b expected fsr %h timeout %b",
               name, done_fsr, done_to, exp_fsr, exp_to);
    end
`ifdef FLASH_RESCUE_ERRCHK_EN
    n_checks++;
    if (done_err !== exp_err) begin
      n_errors++;
      $display("FAIL %s err: got %b expected %b", name, done_err, exp_err);
    end
`endif
    n_checks++;
    if (fsr_o !== exp_fsr || busy_o !== 1'b0 || csn_o !== 1'b1) begin
      n_errors++;
      $display("FAIL %s hold: fsr_o %h busy %b csn %b expected fsr %h busy 0 csn 1",
               name, fsr_o, busy_o, csn_o, exp_fsr);
    end
    if (exp_err) ; // exp_err only compared when the error check is built in
  endtask

  task automatic run_seq(input string name, input bit skip);
    clear_monitor();
    do_start(skip);
    wait_done(name);
    compare_with_model(name, skip);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    start_i = 1'b0;
    skip_rescue_i = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (csn_o !== 1'b1 || sck_o !== 1'b0 || sd_o !== 4'h0 || sd_oe_o !== 4'h0) begin
      n_errors++;
      $display("FAIL reset_pins: csn %b sck %b sd %h oe %h expected 1 0 0 0", csn_o, sck_o, sd_o, sd_oe_o);
    end
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || timeout_o !== 1'b0 || fsr_o !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_status: busy %b done %b timeout %b fsr %h expected 0 0 0 00",
               busy_o, done_o, timeout_o, fsr_o);
    end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rescue_ready();
    resp = '{8'h80};
    run_seq("rescue_ready", 1'b0);
  endtask

  task automatic test_poll_three();
    resp = '{8'h00, 8'h00, 8'h81};
    run_seq("poll_three", 1'($urandom_range(0, 1)));
  endtask

  task automatic test_timeout();
    resp = '{8'h00};
    run_seq("timeout", 1'($urandom_range(0, 1)));
  endtask

  task automatic test_skip();
    resp = '{8'h80};
    run_seq("skip", 1'b1);
    n_checks++;
    if (f_bits.size() == 0 || f_bits[0][15:8] !== 8'h70) begin
      n_errors++;
      $display("FAIL skip_opcode: first frame opcode %h expected 70",
               (f_bits.size() == 0) ? 8'hxx : f_bits[0][15:8]);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    resp = '{8'h80};
    clear_monitor();
    do_start(1'b0);
    cyc = 0;
    while (!(f_len.size() == 2 && !csn_o && cur_len >= 5) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc >= 2000) begin
      n_errors++;
      $display("FAIL reset_mid: RE frame not reached");
    end
    rst_ni = 1'b0;
    @(negedge clk);
    n_checks++;
    if (csn_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || sck_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_abort: csn %b busy %b done %b sck %b expected 1 0 0 0",
               csn_o, busy_o, done_o, sck_o);
    end
    rst_ni = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_cnt !== 0) begin
      n_errors++;
      $display("FAIL reset_mid_done: got %0d done pulses expected 0", done_cnt);
    end
    run_seq("reset_mid_rerun", 1'b0);
  endtask

  task automatic test_back_to_back();
    int cyc;
    resp = '{8'h00, 8'h81};
    clear_monitor();
    do_start(1'b0);
    cyc = 0;
    while (f_len.size() < 2 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b1;
    skip_rescue_i = 1'b1;
    repeat (3) @(negedge clk);
    start_i = 1'b0;
    skip_rescue_i = 1'b0;
    wait_done("ignore_start");
    compare_with_model("ignore_start", 1'b0);
    resp = '{8'h80};
    run_seq("back_to_back", 1'b1);
  endtask

  task automatic test_random();
    int n;
    bit skip;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, POLL_MAX + 1);
      resp.delete();
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'($urandom) & 8'h7F;
        if (ERRCHK && $urandom_range(0, 3) != 0) b[5:1] = 5'b0;
        resp.push_back(b);
      end
      if ($urandom_range(0, 1) == 1) resp[n-1][7] = 1'b1;
      skip = 1'($urandom_range(0, 1));
      run_seq($sformatf("random%0d", it), skip);
    end
  endtask

`ifdef FLASH_RESCUE_ERRCHK_EN
  task automatic test_err_stop();
    resp = '{8'h20, 8'h80};
    run_seq("err_stop", 1'($urandom_range(0, 1)));
  endtask
`endif

  initial begin
    test_reset();
    test_rescue_ready();
    test_poll_three();
    test_timeout();
    test_skip();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef FLASH_RESCUE_ERRCHK_EN
    test_err_stop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_rescue_seq.md
Name: spi_flash_rescue_seq

Overview:
- Controller that sequences an N25Q-class serial NOR flash out of an unknown protocol state after power loss.
- Issues the four-part power-loss rescue sequence (quad, dual, extended part 1, then part 2), waits a recovery time, then polls the Flag Status Register (opcode 0x70) until ready or timeout.
- Sits between the SoC boot/flash controller and the flash pads; owns the SPI pins only while busy_o is high.

Parameters:
- CLK_DIV, 2, clk_i cycles per SCK half-period (>=1)
- N_QUAD, 7, part-1 quad SCK pulses
- N_DUAL, 13, part-1 dual SCK pulses
- N_EXT, 25, part-1 extended SCK pulses
- N_P2, 8, part-2 SCK pulses
- CS_GAP, 4, clk_i cycles with csn_o high between frames
- RESC_WAIT, 16, clk_i cycles of idle after part 2 before the first poll
- POLL_MAX, 8, maximum FSR reads before timeout

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous reset, active low
- start_i  in  1  start sequence; sampled only in IDLE
- skip_rescue_i  in  1  sampled with start_i; 1 = go straight to FSR polling
- busy_o  out  1  high from the accepted start until done
- done_o  out  1  one-cycle pulse at completion
- timeout_o  out  1  valid with done_o; 1 = FSR[7] never set
- fsr_o  out  8  last FSR byte read; held until next start
- sck_o  out  1  SPI clock, idle low (mode 0)
- csn_o  out  1  chip select, idle high
- sd_o  out  4  DQ[3:0] output data
- sd_oe_o  out  4  DQ[3:0] output enables
- sd_i  in  4  DQ[3:0] input data

Behaviour:
- Reset values (rst_ni low at a rising clk_i edge):
  - state IDLE; csn_o=1, sck_o=0, sd_o=0, sd_oe_o=0
  - busy_o=0, done_o=0, timeout_o=0, fsr_o=8'h00; all counters 0
- SCK timing:
  - One SCK pulse = CLK_DIV cycles low, then CLK_DIV cycles high.
  - Outputs change only during the low phase; sd_i[1] is sampled on the clk_i cycle where sck_o rises.
  - csn_o falls one full half-period before the first SCK rise.
  - csn_o rises CLK_DIV cycles after the last SCK fall.
- FSM states: IDLE -> RQ -> G1 -> RD -> G2 -> RE -> G3 -> P2 -> WAIT -> CMD -> RDB -> PG -> (CMD | FIN) -> IDLE.
- RQ / RD / RE (rescue part 1):
  - csn_o=0, sd_oe_o=4'b0001, sd_o[0]=1.
  - Issue N_QUAD / N_DUAL / N_EXT pulses respectively, then raise csn_o.
- G1 / G2 / G3: csn_o=1, sck_o=0, sd_oe_o=0 for CS_GAP cycles.
- P2: csn_o=0, sd_o[0]=1 for N_P2 pulses, then csn_o=1.
- WAIT: RESC_WAIT idle cycles.
- CMD:
  - csn_o=0, sd_oe_o=4'b0001.
  - Shift 8'h70 MSB first on sd_o[0], 8 pulses.
- RDB:
  - sd_oe_o=0.
  - Shift in 8 bits from sd_i[1], MSB first, 8 pulses; then csn_o=1.
  - fsr_o updates when the 8th bit is sampled.
- PG: CS_GAP cycles with csn_o high. The poll counter increments once per completed read. Then:
  - if fsr_o[7]=1: go to FIN, timeout_o=0
  - else if poll count == POLL_MAX: go to FIN, timeout_o=1
  - else: go to CMD
- FIN: done_o=1 for one cycle, busy_o falls in the same cycle, return to IDLE.
- skip_rescue_i=1 with start: IDLE -> CMD directly.
- busy_o=1 in every state except IDLE.
- start_i while busy is ignored, with no queuing.
- Reset mid-frame: csn_o returns high and the sequence aborts on that same edge; no done_o pulse is issued.
- Counter widths are derived with $clog2(max+1).
- A poll count that reaches POLL_MAX exactly on a read with FSR[7]=1 reports success (ready takes priority).

Optional Feature:
- Macro FLASH_RESCUE_ERRCHK_EN.
- When defined:
  - Adds output err_o (1 bit), valid with done_o.
  - err_o = OR of FSR[5:1] from the final read.
  - Polling also terminates early when any of FSR[5:1] is set, independent of FSR[7].
- When undefined: no err_o port; FSR[5:1] are ignored.

Decomposition:
- Package spi_flash_rescue_pkg:
  - state enum
  - opcode constant FSR_READ_OP = 8'h70
  - FSR bit-index constants (READY=7, ERASE=5, PROG=4, VPP=3, PROT=1)
- Sub-module spi_sck_gen:
  - half-period divider plus pulse counter
  - inputs: load count, go; outputs: sck, rise strobe, fall strobe, last-pulse-done

Test Plan:
- Defaults, start_i=1, flash model FSR=8'h80 on first read -> csn_o low frames of 7, 13, 25 and 8 SCK pulses; 4-cycle high gaps; then one 0x70 frame; fsr_o=8'h80; done_o pulse; timeout_o=0.
- Model returns 8'h00, 8'h00, 8'h81 -> exactly 3 FSR frames; fsr_o=8'h81; timeout_o=0.
- Model always returns 8'h00 -> exactly 8 FSR frames; timeout_o=1; fsr_o=8'h00.
- skip_rescue_i=1 with start_i -> first csn_o frame is the 8-bit opcode 0x70 (sd_o[0] pattern 0,1,1,1,0,0,0,0).
- rst_ni low during the RE frame -> next cycle csn_o=1, busy_o=0, no done_o; a fresh start_i reruns the full sequence from RQ.
- FLASH_RESCUE_ERRCHK_EN defined, model returns 8'h20 -> polling stops after one read; err_o=1; timeout_o=0.
